// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, funct codes, ALU ops,
// operand/PC select codes and the FSM state type.
package ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;
endpackage

// File: rtl/alu_dec.sv
// Combinational op/funct decode: EX-stage ALU operation and legal-encoding flag.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctr,
    output logic       legal
);
    always_comb begin
        alu_ctr = ALU_ADDU;
        legal   = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctr = ALU_ADD;
                    FN_ADDU: alu_ctr = ALU_ADDU;
                    FN_SUBU: alu_ctr = ALU_SUBU;
                    FN_SLT:  alu_ctr = ALU_SLT;
                    default: legal   = 1'b0;
                endcase
            end
            OP_ORI:                      alu_ctr = ALU_OR;
            OP_BEQ:                      alu_ctr = ALU_SUBU;
            OP_ADDIU, OP_LW, OP_SW, OP_J: alu_ctr = ALU_ADDU;
            default:                     legal   = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller (IF/ID/EX/MEM/WB/HALT).
// Build option CTRL_OVF_TRAP_EN: ADD overflow suppresses write-back and sets sticky ovf_flag.
module mc_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [2:0] ALUctr,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSrc,
    output logic       halted,
    output logic       ovf_flag
);
    state_t     state, next;
    logic [2:0] ex_alu;
    logic       legal;
    logic       is_r, is_add, wb_sup;

    assign is_r   = (op == OP_RTYPE);
    assign is_add = is_r && (funct == FN_ADD);

    alu_dec u_dec (
        .op      (op),
        .funct   (funct),
        .alu_ctr (ex_alu),
        .legal   (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IF;
        else     state <= next;
    end

`ifdef CTRL_OVF_TRAP_EN
    logic ovf_hit, ovf_q;
    // ovf_hit is consumed only in the WB cycle right after the ADD's EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_hit <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == S_EX && is_add) begin
            ovf_hit <= Overflow;
            if (Overflow) ovf_q <= 1'b1;
        end
    end
    assign wb_sup   = ovf_hit && is_add;
    assign ovf_flag = ovf_q && !rst;
`else
    logic unused_ovf;
    assign unused_ovf = Overflow;
    assign wb_sup     = 1'b0;
    assign ovf_flag   = 1'b0;
`endif

    always_comb begin
        next     = state;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        ALUctr   = ALU_ADDU;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RT;
        ExtOp    = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        PCSrc    = PCSRC_ALU;
        halted   = 1'b0;
        case (state)
            S_IF: begin
                ALUSrcB = SRCB_FOUR;
                PCWr    = 1'b1;
                IRWr    = 1'b1;
                next    = S_ID;
            end
            S_ID: begin
                ALUSrcB = SRCB_IMM2;
                ExtOp   = 1'b1;
                next    = legal ? S_EX : S_HALT;
            end
            S_EX: begin
                ALUctr = ex_alu;
                case (op)
                    OP_RTYPE: begin ALUSrcA = 1'b1; next = S_WB; end
                    OP_ORI:   begin ALUSrcB = SRCB_IMM; next = S_WB; end
                    OP_ADDIU: begin ALUSrcB = SRCB_IMM; ExtOp = 1'b1; next = S_WB; end
                    OP_LW, OP_SW: begin ALUSrcB = SRCB_IMM; ExtOp = 1'b1; next = S_MEM; end
                    OP_BEQ:   begin PCSrc = PCSRC_BR; PCWr = Zero; next = S_IF; end
                    OP_J:     begin PCSrc = PCSRC_JMP; PCWr = 1'b1; next = S_IF; end
                    default:  next = S_HALT;
                endcase
            end
            S_MEM: begin
                if (op == OP_LW) next = S_WB;
                else begin
                    MemWr = 1'b1;
                    next  = S_IF;
                end
            end
            S_WB: begin
                RegWr    = !wb_sup;
                RegDst   = is_r;
                MemtoReg = (op == OP_LW);
                next     = S_IF;
            end
            S_HALT:  halted = 1'b1;
            default: next = S_HALT;
        endcase
        // Reset blanks every output, including the Zero-driven PCWr.
        if (rst) begin
            PCWr = 1'b0; IRWr = 1'b0; RegWr = 1'b0; MemWr = 1'b0;
            ALUctr = ALU_ADDU; ALUSrcA = 1'b0; ALUSrcB = SRCB_RT; ExtOp = 1'b0;
            RegDst = 1'b0; MemtoReg = 1'b0; PCSrc = PCSRC_ALU; halted = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes per-cycle expected outputs
// from an instruction-level model; a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    logic rst, Zero, Overflow;
    logic [5:0] op, funct;
    logic PCWr, IRWr, RegWr, MemWr, ALUSrcA, ExtOp, RegDst, MemtoReg, halted, ovf_flag;
    logic [2:0] ALUctr;
    logic [1:0] ALUSrcB, PCSrc;

    typedef struct packed {
        logic       pcwr, irwr, regwr, memwr;
        logic [2:0] aluctr;
        logic       srca;
        logic [1:0] srcb;
        logic       ext, regdst, m2r;
        logic [1:0] pcsrc;
        logic       hlt, ovf;
    } outs_t;

    typedef struct packed {
        logic [3:0] ph;
        outs_t      o;
    } item_t;

    localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5, P_RST = 6;

    item_t q[$];
    int total = 0, bad = 0;
    bit sticky = 1'b0;
    bit hit = 1'b0;
    outs_t got;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .Zero(Zero), .Overflow(Overflow),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .ALUctr(ALUctr),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .PCSrc(PCSrc), .halted(halted), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    assign got = {PCWr, IRWr, RegWr, MemWr, ALUctr, ALUSrcA, ALUSrcB, ExtOp,
                  RegDst, MemtoReg, PCSrc, halted, ovf_flag};

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                total++;
                if (got !== it.o) begin
                    bad++;
                    $display("FAIL phase%0d op=%b funct=%b t=%0t got=%h want=%h",
                             it.ph, op, funct, $time, got, it.o);
                end
            end
        end
    end

    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: return (f == 6'b100000 || f == 6'b100001 || f == 6'b100011 || f == 6'b101010);
            6'b001101, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level reference: what each phase of an instruction must drive.
    function automatic outs_t model(input int ph, input logic [5:0] o, input logic [5:0] f,
                                    input logic z, input bit stk, input bit h);
        outs_t e = '0;
        if (ph == P_RST) return e;
        e.ovf = stk;
        case (ph)
            P_IF: begin e.pcwr = 1; e.irwr = 1; e.srcb = 2'b01; end
            P_ID: begin e.srcb = 2'b11; e.ext = 1; end
            P_EX: begin
                if (o == 6'b000000) begin
                    e.srca = 1;
                    e.aluctr = (f == 6'b100000) ? 3'b001 : (f == 6'b100001) ? 3'b000 :
                               (f == 6'b100011) ? 3'b101 : 3'b111;
                end else if (o == 6'b001101) begin e.srcb = 2'b10; e.aluctr = 3'b010; end
                else if (o == 6'b000100) begin e.aluctr = 3'b101; e.pcsrc = 2'b01; e.pcwr = z; end
                else if (o == 6'b000010) begin e.pcsrc = 2'b10; e.pcwr = 1; end
                else begin e.srcb = 2'b10; e.ext = 1; end
            end
            P_MEM: e.memwr = (o == 6'b101011);
            P_WB: begin e.regwr = !h; e.regdst = (o == 6'b000000); e.m2r = (o == 6'b100011); end
            P_HALT: e.hlt = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic push(input int ph);
        item_t it;
        it.ph = ph[3:0];
        it.o  = model(ph, op, funct, Zero, sticky, hit);
        q.push_back(it);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1; Zero = $urandom_range(1); Overflow = $urandom_range(1);
            push(P_RST);
            sticky = 0; hit = 0;
            @(posedge clk); #1;
        end
        rst = 0;
    endtask

    // mode 0/1 = fixed flag value, 2 = random each cycle; abort_at = phase index to reset in (-1 none)
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int zm, input int om,
                            input int nhalt, input int abort_at);
        int phs[$];
        phs.push_back(P_IF); phs.push_back(P_ID);
        if (!is_legal(o, f)) for (int i = 0; i < nhalt; i++) phs.push_back(P_HALT);
        else begin
            phs.push_back(P_EX);
            if (o == 6'b100011) begin phs.push_back(P_MEM); phs.push_back(P_WB); end
            else if (o == 6'b101011) phs.push_back(P_MEM);
            else if (o != 6'b000100 && o != 6'b000010) phs.push_back(P_WB);
        end
        hit = 0;
        op = o; funct = f;
        for (int k = 0; k < phs.size(); k++) begin
            if (k == abort_at) begin do_reset(1); return; end
            Zero     = (zm == 2) ? 1'($urandom_range(1)) : zm[0];
            Overflow = (om == 2) ? 1'($urandom_range(1)) : om[0];
            push(phs[k]);
`ifdef CTRL_OVF_TRAP_EN
            if (phs[k] == P_EX && o == 6'b000000 && f == 6'b100000 && Overflow) begin
                sticky = 1; hit = 1;
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] ops [8];
    logic [5:0] fns [4];

    initial begin : stim
        ops = '{6'b000000, 6'b001101, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100001, 6'b100011, 6'b101010};
        rst = 1; op = 0; funct = 0; Zero = 0; Overflow = 0;
        @(posedge clk); #1;
        do_reset(2);
        do_instr(6'b000000, 6'b100001, 2, 2, 0, -1);   // ADDU
        do_instr(6'b100011, 6'b000000, 2, 2, 0, -1);   // LW
        do_instr(6'b101011, 6'b000000, 2, 2, 0, -1);   // SW
        do_instr(6'b000100, 6'b000000, 1, 2, 0, -1);   // BEQ taken
        do_instr(6'b000100, 6'b000000, 0, 2, 0, -1);   // BEQ not taken
        do_instr(6'b000000, 6'b100000, 2, 1, 0, -1);   // ADD overflow
        do_instr(6'b000000, 6'b100001, 2, 1, 0, -1);   // ADDU with Overflow high: no effect
        do_instr(6'b001101, 6'b000000, 2, 2, 0, -1);   // ORI
        do_instr(6'b111111, 6'b000000, 2, 2, 20, -1);  // illegal -> HALT
        do_reset(1);
        do_instr(6'b000010, 6'b000000, 2, 2, 0, -1);   // J after halt
        do_instr(6'b101011, 6'b000000, 2, 2, 0, 3);    // reset in SW MEM
        do_instr(6'b000000, 6'b101010, 2, 2, 0, -1);   // SLT
        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            int ab;
            o = ops[$urandom_range(7)];
            f = (o == 6'b000000) ? fns[$urandom_range(3)] : 6'($urandom);
            if ($urandom_range(15) == 0) begin
                o = 6'($urandom);
                f = 6'($urandom);
            end
            ab = ($urandom_range(19) == 0) ? int'($urandom_range(4)) : -1;
            do_instr(o, f, 2, 2, 3, ab);
            if (!is_legal(o, f) && ab < 0) do_reset(1);
        end
        @(posedge clk); @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle main controller for the CPU datapath; sits directly upstream of the ALU and drives its `ALUctr` plus all operand-select and write-enable strobes for the datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states, samples the ALU `Zero`/`Overflow` flags for branch and overflow handling, and halts on an unrecognised encoding.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `op` in 6: IR[31:26], held stable by the IR register.
- `funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag.
- `Overflow` in 1: ALU signed-overflow flag.
- `PCWr` out 1: PC write enable.
- `IRWr` out 1: IR write enable.
- `RegWr` out 1: register-file write enable.
- `MemWr` out 1: data-memory write enable.
- `ALUctr` out 3: ALU operation; 000 addu, 001 add (overflow checked), 010 or, 101 subu, 111 slt.
- `ALUSrcA` out 1: 0 = PC, 1 = rs.
- `ALUSrcB` out 2: 00 rt, 01 constant 4, 10 extended imm, 11 extended imm << 2.
- `ExtOp` out 1: 1 = sign-extend, 0 = zero-extend.
- `RegDst` out 1: 1 = rd, 0 = rt.
- `MemtoReg` out 1: 1 = memory data, 0 = ALU result.
- `PCSrc` out 2: 00 ALU result, 01 branch target register, 10 jump target.
- `halted` out 1: in HALT state.
- `ovf_flag` out 1: sticky ADD-overflow indicator.

## Operation
- States: IF, ID, EX, MEM, WB, HALT. 3-bit encoding in package.
- IF: ALUSrcA=0, ALUSrcB=01, ALUctr=000, PCSrc=00, PCWr=1, IRWr=1. Next: ID.
- ID: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=000; branch target is latched externally. Decode op/funct. Legal encodings: R-type (op 000000, funct ADD 100000, ADDU 100001, SUBU 100011, SLT 101010), ORI 001101, ADDIU 001001, LW 100011, SW 101011, BEQ 000100, J 000010. Next: EX, or HALT if illegal.
- EX:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUctr from funct.
  - ORI: ALUSrcB=10, ExtOp=0, ALUctr=010.
  - ADDIU/LW/SW: ALUSrcB=10, ExtOp=1, ALUctr=000.
  - BEQ: ALUSrcB=00, ALUctr=101, PCSrc=01, PCWr=Zero. Next: IF.
  - J: PCSrc=10, PCWr=1. Next: IF.
  - LW/SW next: MEM. Others next: WB.
- MEM: LW next WB; SW asserts MemWr=1, next IF.
- WB: RegWr=1. RegDst=1 for R-type, 0 otherwise. MemtoReg=1 only for LW. Next: IF.
- HALT: all enables 0; remains in HALT until `rst`.
- Strobes not listed for a state are 0. Mux selects not listed for a state are don't-care, driven 0.
- Cycles per instruction: BEQ/J 3, R-type/ORI/ADDIU/SW 4, LW 5.

## Timing
- Moore outputs: combinational from registered state and the current `op`/`funct`. Exception: BEQ `PCWr` in EX is combinational from `Zero`.
- `Overflow` is sampled at the EX→WB edge for ADD only.
- Reset: while `rst`=1, state←IF and ovf_flag←0 on the next edge. All outputs are forced 0 during reset, including `halted`.
- First fetch strobe is asserted in the first cycle after `rst` deasserts.
- `rst` mid-instruction, including in MEM of SW or in HALT, aborts unconditionally. MemWr/RegWr are not asserted in the reset cycle.
- `op`/`funct` must stay constant from ID through WB; only IF loads the IR.

## Configuration
- `CTRL_OVF_TRAP_EN` defined:
  - ADD with `Overflow`=1 in EX suppresses RegWr in WB.
  - ovf_flag sets to 1 and stays set until `rst`.
- Undefined:
  - ADD writes back regardless of `Overflow`.
  - ovf_flag is tied to 0.
  - ALUctr for ADD remains 001.

## Structure
- Package `ctrl_pkg`: opcode/funct localparams, ALUctr codes, state encoding, ALUSrcB/PCSrc codes.
- Sub-module `alu_dec`: combinational op/funct → ALUctr plus legal-instruction flag, instantiated once.

## Test plan
- Reset, then ADDU (funct 100001), X=0x22222222, Y=0x11111111 → states IF,ID,EX,WB. ALUctr=000 in EX; RegWr=1 and RegDst=1 in WB only; 4 cycles.
- LW then SW → LW takes 5 cycles with MemtoReg=1 in WB. SW asserts MemWr exactly one cycle, in MEM; RegWr never asserted.
- BEQ with Zero=1, then with Zero=0 → ALUctr=101, PCSrc=01 in EX. PCWr=1 for the first case and 0 for the second; both take 3 cycles.
- ADD with Overflow=1 → with `CTRL_OVF_TRAP_EN`: RegWr=0 in WB and ovf_flag=1 held across later instructions. Without the macro: RegWr=1 and ovf_flag=0.
- op=111111 → HALT after ID. halted=1 and all enables 0 for 20 cycles; `rst` pulse returns to IF.
- Assert `rst` in MEM of SW → MemWr=0 in that cycle; state=IF after the edge.
